// File: rtl/control_step_sequencer_pkg.sv
// Shared types and defaults for the control step sequencer.
//   DEF_*        default parameter values for the sequencer and its bus
//   IDX_W        width of the stage index and of timeout_stage
//   seq_state_e  sequencer state encoding
package control_step_sequencer_pkg;

  localparam int unsigned DEF_N_STAGES = 4;
  localparam int unsigned DEF_TIMEOUT  = 64;
  localparam int unsigned DEF_CNT_W    = 32;
  localparam int unsigned IDX_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } seq_state_e;

endpackage

// File: rtl/control_step_sequencer_if.sv
// sta/done_sig/control_valuation_sig bundle between the step sequencer and its environment.
//   master: the sequencer (drives sta, commit/clear pulses, status)
//   slave : the environment (drives step_tick, user_clear, err_clear, done_sig)
interface control_step_sequencer_if
  import control_step_sequencer_pkg::*;
#(
  parameter int unsigned N_STAGES = DEF_N_STAGES,
  parameter int unsigned CNT_W    = DEF_CNT_W
) ();

  logic                step_tick;
  logic                user_clear;
  logic                err_clear;
  logic [N_STAGES-1:0] done_sig;
  logic [N_STAGES-1:0] sta;
  logic                control_valuation_sig;
  logic                rst_user;
  logic                step_done;
  logic                busy;
  logic [CNT_W-1:0]    step_count;
  logic                overrun_err;
  logic                timeout_err;
  logic [IDX_W-1:0]    timeout_stage;

  modport master (
    input  step_tick, user_clear, err_clear, done_sig,
    output sta, control_valuation_sig, rst_user, step_done, busy,
           step_count, overrun_err, timeout_err, timeout_stage
  );

  modport slave (
    output step_tick, user_clear, err_clear, done_sig,
    input  sta, control_valuation_sig, rst_user, step_done, busy,
           step_count, overrun_err, timeout_err, timeout_stage
  );

endinterface

// File: rtl/control_step_sequencer_stage_watchdog.sv
// Per-stage watchdog: counts cycles since it was cleared, saturating at TIMEOUT.
//   clk, rst   clock, synchronous active-high reset
//   clear_i    restart the count at zero
//   enable_i   advance the count this cycle
//   expired_o  TIMEOUT cycles will have elapsed at the end of this cycle
module control_step_sequencer_stage_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;

  // Saturating count; never wraps back to a non-expired value
  always_comb begin
    wd_d = wd_q;
    if (clear_i) begin
      wd_d = '0;
    end else if (enable_i && (wd_q != WD_W'(TIMEOUT))) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  // Count is zero in the sta cycle, so TIMEOUT-1 marks the last allowed done cycle
  assign expired_o = (wd_q >= WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/control_step_sequencer.sv
// Initiator of the per-timestep sta/done_sig handshake across N_STAGES control stages,
// followed by a control_valuation_sig commit pulse; also issues rst_user history clears
// and tracks overrun / stage-timeout faults.
//   clk, rst  clock, synchronous active-high reset
//   bus       control_step_sequencer_if.master (all outputs registered)
module control_step_sequencer
  import control_step_sequencer_pkg::*;
#(
  parameter int unsigned N_STAGES = DEF_N_STAGES,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input logic                      clk,
  input logic                      rst,
  control_step_sequencer_if.master bus
);

  seq_state_e          state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [N_STAGES-1:0] sta_q;
  logic                cv_q;
  logic                rst_user_q;
  logic                step_done_q;
  logic                busy_q;
  logic [CNT_W-1:0]    step_count_q;
  logic                overrun_err_q;
  logic                timeout_err_q;
  logic [IDX_W-1:0]    timeout_stage_q;

  logic [N_STAGES-1:0] done_shift_c;
  logic                cur_done_c;
  logic                last_stage_c;
  logic                wd_clear_c;
  logic                wd_enable_c;
  logic                wd_expired_c;

  // Only the done bit of the stage currently being waited on matters
  assign done_shift_c = bus.done_sig >> idx_q;
  assign cur_done_c   = done_shift_c[0];
  assign last_stage_c = (idx_q == IDX_W'(N_STAGES - 1));

  // Watchdog restarts as ISSUE is entered so its count equals cycles since sta
  assign wd_clear_c  = ((state_q == ST_IDLE) && bus.step_tick) ||
                       ((state_q == ST_WAIT) && cur_done_c && !last_stage_c);
  assign wd_enable_c = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  control_step_sequencer_stage_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_stage_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (wd_clear_c),
    .enable_i  (wd_enable_c),
    .expired_o (wd_expired_c)
  );

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      sta_q           <= '0;
      cv_q            <= 1'b0;
      rst_user_q      <= 1'b0;
      step_done_q     <= 1'b0;
      busy_q          <= 1'b0;
      step_count_q    <= '0;
      overrun_err_q   <= 1'b0;
      timeout_err_q   <= 1'b0;
      timeout_stage_q <= '0;
    end else begin
      sta_q       <= '0;
      cv_q        <= 1'b0;
      rst_user_q  <= 1'b0;
      step_done_q <= 1'b0;

      // Later assignments below win, so a fresh fault overrides err_clear
      if (bus.err_clear) begin
        overrun_err_q <= 1'b0;
        timeout_err_q <= 1'b0;
      end
      if ((state_q != ST_IDLE) && bus.step_tick) begin
        overrun_err_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.step_tick) begin
            idx_q   <= '0;
            sta_q   <= N_STAGES'(1);
            busy_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end else if (bus.user_clear) begin
            rst_user_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cur_done_c) begin
            if (last_stage_c) begin
              cv_q         <= 1'b1;
              step_done_q  <= 1'b1;
              step_count_q <= step_count_q + CNT_W'(1);
              state_q      <= ST_COMMIT;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              sta_q   <= N_STAGES'(1) << (idx_q + IDX_W'(1));
              state_q <= ST_ISSUE;
            end
          end else if (wd_expired_c) begin
            timeout_err_q   <= 1'b1;
            timeout_stage_q <= idx_q;
            busy_q          <= 1'b0;
            state_q         <= ST_IDLE;
          end
        end
        ST_COMMIT: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sta                   = sta_q;
  assign bus.control_valuation_sig = cv_q;
  assign bus.rst_user              = rst_user_q;
  assign bus.step_done             = step_done_q;
  assign bus.busy                  = busy_q;
  assign bus.step_count            = step_count_q;
  assign bus.overrun_err           = overrun_err_q;
  assign bus.timeout_err           = timeout_err_q;
  assign bus.timeout_stage         = timeout_stage_q;

endmodule

// File: tb/tb_control_step_sequencer.sv
// Bench for control_step_sequencer: stage responders, a timestamp-based reference model
// checked every cycle, and directed scenarios with hand-computed timing expectations.
module tb_control_step_sequencer;

  localparam int N  = 4;
  localparam int TO = 64;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  control_step_sequencer_if #(.N_STAGES(N), .CNT_W(CW)) bus ();

  control_step_sequencer #(
    .N_STAGES (N),
    .TIMEOUT  (TO),
    .CNT_W    (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- stage responders ----------------
  int       lat [N];          // 0 = stage never answers
  logic [N-1:0] done_model;
  logic [N-1:0] spur;
  bit       armed [N];
  int       due   [N];

  assign bus.done_sig = done_model | spur;

  initial begin
    done_model = '0;
    for (int k = 0; k < N; k++) armed[k] = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        done_model[k] = armed[k] && (due[k] == cyc);
        if (done_model[k]) armed[k] = 1'b0;
      end
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (bus.sta[k] && lat[k] != 0) begin
          armed[k] = 1'b1;
          due[k]   = cyc + lat[k];
        end
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  bit           p_rst, p_tick, p_uc, p_ec;
  logic [N-1:0] p_done;
  bit           m_valid = 0;
  bit           m_busy, m_commit;
  int           m_stage, m_sta_cyc;
  logic [N-1:0] e_sta;
  bit           e_cv, e_ru, e_sd, e_ovr, e_to;
  logic [CW-1:0] e_cnt;
  int           e_ts;
  bit           preload_pulse = 0;
  logic [CW-1:0] preload_val;

  int t_sta [N];
  int t_cv, t_fall, t_to_rise, t_ru;
  int n_cv = 0, n_sd = 0, n_ru = 0;
  bit prev_busy = 0, prev_to = 0;

  always @(negedge clk) begin
    e_sta = '0; e_cv = 0; e_ru = 0; e_sd = 0;
    if (p_rst) begin
      m_busy = 0; m_commit = 0; m_stage = 0; m_sta_cyc = 0;
      e_cnt = '0; e_ovr = 0; e_to = 0; e_ts = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (p_ec) begin e_ovr = 0; e_to = 0; end
      if (p_tick && m_busy) e_ovr = 1;
      if (!m_busy) begin
        if (p_tick) begin
          m_busy = 1; m_stage = 0; m_sta_cyc = cyc; e_sta[0] = 1'b1;
        end else if (p_uc) begin
          e_ru = 1;
        end
      end else if (m_commit) begin
        m_busy = 0; m_commit = 0;
      end else begin
        // previous cycle is cyc-1; the sta cycle itself cannot complete a stage
        if ((cyc - 1 > m_sta_cyc) && p_done[m_stage]) begin
          if (m_stage == N - 1) begin
            m_commit = 1; e_cv = 1; e_sd = 1; e_cnt = e_cnt + 1'b1;
          end else begin
            m_stage++; m_sta_cyc = cyc; e_sta[m_stage] = 1'b1;
          end
        end else if (cyc - 1 >= m_sta_cyc + TO - 1) begin
          e_to = 1; e_ts = m_stage; m_busy = 0;
        end
      end
      if (preload_pulse) e_cnt = preload_val;
    end

    if (m_valid) begin
      chk("sta",           bus.sta,                   e_sta);
      chk("commit",        bus.control_valuation_sig, e_cv);
      chk("rst_user",      bus.rst_user,              e_ru);
      chk("step_done",     bus.step_done,             e_sd);
      chk("busy",          bus.busy,                  m_busy);
      chk("step_count",    bus.step_count,            e_cnt);
      chk("overrun_err",   bus.overrun_err,           e_ovr);
      chk("timeout_err",   bus.timeout_err,           e_to);
      chk("timeout_stage", bus.timeout_stage,         e_ts);
    end

    for (int k = 0; k < N; k++) if (bus.sta[k]) t_sta[k] = cyc;
    if (bus.control_valuation_sig) begin t_cv = cyc; n_cv++; end
    if (bus.step_done) n_sd++;
    if (bus.rst_user) begin t_ru = cyc; n_ru++; end
    if (prev_busy && !bus.busy) t_fall = cyc;
    if (!prev_to && bus.timeout_err) t_to_rise = cyc;
    prev_busy = bus.busy;
    prev_to   = bus.timeout_err;

    p_rst = rst; p_tick = bus.step_tick; p_uc = bus.user_clear;
    p_ec = bus.err_clear; p_done = bus.done_sig;
  end

  // ---------------- directed scenarios ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (bus.busy && k < budget) begin step(1); k++; end
    chk("idle_within_budget", bus.busy, 0);
  endtask

  task automatic pulse_tick();
    bus.step_tick = 1'b1; step(1); bus.step_tick = 1'b0;
  endtask

  task automatic pulse_uc();
    bus.user_clear = 1'b1; step(1); bus.user_clear = 1'b0;
  endtask

  task automatic pulse_ec();
    bus.err_clear = 1'b1; step(1); bus.err_clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int t, u, base;
    bus.step_tick = 1'b0; bus.user_clear = 1'b0; bus.err_clear = 1'b0;
    spur = '0;
    lat = '{19, 19, 5, 3};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_sta",        bus.sta, 0);
    chk("rst_busy",       bus.busy, 0);
    chk("rst_step_count", bus.step_count, 0);
    chk("rst_overrun",    bus.overrun_err, 0);
    chk("rst_timeout",    bus.timeout_err, 0);
    chk("rst_tstage",     bus.timeout_stage, 0);

    // 1: normal step, tick in cycle 10
    goto_cycle(10);
    t = cyc;
    pulse_tick();
    wait_idle(200); step(2);
    chk("t1_sta0",  t_sta[0], 11);
    chk("t1_sta1",  t_sta[1], 31);
    chk("t1_sta2",  t_sta[2], 51);
    chk("t1_sta3",  t_sta[3], 57);
    chk("t1_commit", t_cv, 61);
    chk("t1_busy_fall", t_fall, 62);
    chk("t1_count", bus.step_count, 1);

    // 2: stage 2 never answers
    lat[2] = 0;
    base = n_cv;
    pulse_tick();
    wait_idle(300); step(2);
    chk("t2_timeout_latency", t_to_rise - t_sta[2], TO);
    chk("t2_timeout_stage", bus.timeout_stage, 2);
    chk("t2_no_commit", n_cv - base, 0);
    chk("t2_count", bus.step_count, 1);
    lat[2] = 5;
    pulse_tick();
    wait_idle(200); step(2);
    chk("t2_clean_count", bus.step_count, 2);
    chk("t2_sticky", bus.timeout_err, 1);
    pulse_ec();
    chk("t2_cleared", bus.timeout_err, 0);

    // 3: overrun
    base = n_sd;
    pulse_tick();
    step(4);
    pulse_tick();
    wait_idle(200); step(2);
    chk("t3_one_step_done", n_sd - base, 1);
    chk("t3_overrun", bus.overrun_err, 1);
    pulse_ec();
    chk("t3_cleared", bus.overrun_err, 0);
    pulse_tick();
    step(3);
    bus.step_tick = 1'b1; bus.err_clear = 1'b1;
    step(1);
    bus.step_tick = 1'b0; bus.err_clear = 1'b0;
    chk("t3_set_beats_clear", bus.overrun_err, 1);
    wait_idle(200); step(2);
    pulse_ec();

    // 4: user_clear
    base = n_ru;
    u = cyc;
    pulse_uc();
    step(2);
    chk("t4_rst_user_delay", t_ru - u, 1);
    chk("t4_rst_user_once", n_ru - base, 1);
    pulse_tick();
    step(5);
    pulse_uc();
    wait_idle(200); step(2);
    chk("t4_no_clear_in_wait", n_ru - base, 1);
    bus.step_tick = 1'b1; bus.user_clear = 1'b1;
    step(1);
    bus.step_tick = 1'b0; bus.user_clear = 1'b0;
    chk("t4_tick_wins_busy", bus.busy, 1);
    wait_idle(200); step(2);
    chk("t4_tick_wins_no_clear", n_ru - base, 1);

    // 5: reset during stage 1 wait
    t = cyc;
    pulse_tick();
    goto_cycle(t + 25);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("t5_busy", bus.busy, 0);
    chk("t5_count", bus.step_count, 0);
    chk("t5_sta", bus.sta, 0);
    step(20);
    chk("t5_late_done_ignored", bus.busy, 0);
    pulse_tick();
    wait_idle(200); step(2);
    chk("t5_count_after", bus.step_count, 1);

    // 6: edge cases
    lat[0] = TO - 1;
    pulse_tick();
    wait_idle(400); step(2);
    chk("t6_exact_expiry_no_timeout", bus.timeout_err, 0);
    chk("t6_exact_expiry_count", bus.step_count, 2);
    lat[0] = TO;
    pulse_tick();
    wait_idle(400); step(2);
    chk("t6_one_late_timeout", bus.timeout_err, 1);
    chk("t6_one_late_stage", bus.timeout_stage, 0);
    chk("t6_one_late_count", bus.step_count, 2);
    pulse_ec();
    lat[0] = 19;
    t = cyc;
    pulse_tick();
    spur = 4'b0001; step(1); spur = '0;
    step(2);
    spur = 4'b1000; step(1); spur = '0;
    wait_idle(200); step(2);
    chk("t6_spurious_ignored", t_sta[1] - t, 21);
    chk("t6_spurious_count", bus.step_count, 3);

    preload_val = 32'hFFFF_FFFF;
    preload_pulse = 1;
    force dut.step_count_q = 32'hFFFF_FFFF;
    #1 release dut.step_count_q;
    step(1);
    preload_pulse = 0;
    chk("t6_preload", bus.step_count, 64'h0000_0000_FFFF_FFFF);
    pulse_tick();
    wait_idle(200); step(2);
    chk("t6_wrap", bus.step_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
